// File: rtl/rr_pkg.sv
// rr_pkg: shared types and defaults for the rr_grant_indexer slice.
//   state_t      - arbiter FSM states (IDLE, GRANT)
//   DEF_*        - default parameter values for the arbiter
//   cnt_width()  - bit width needed to hold the values 0..max_val
package rr_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int unsigned DEF_IN_WIDTH = 2;
  localparam int unsigned DEF_N_REQ    = 4;
  localparam int unsigned DEF_MAX_HOLD = 15;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: purely combinational rotating priority encoder.
// Ports:
//   req       [N_REQ]    request lines
//   start     [IN_WIDTH] index searched first; the search wraps from N_REQ-1 to 0
//   excl      [N_REQ]    requesters to skip during this search
//   winner    [IN_WIDTH] first requester found ('0 when none)
//   any_valid            a winner was found
// N_REQ must equal 2**IN_WIDTH, so index arithmetic wraps naturally.
module rr_pick
  import rr_pkg::*;
#(
  parameter int unsigned IN_WIDTH = DEF_IN_WIDTH,
  parameter int unsigned N_REQ    = DEF_N_REQ
) (
  input  logic [N_REQ-1:0]    req,
  input  logic [IN_WIDTH-1:0] start,
  input  logic [N_REQ-1:0]    excl,
  output logic [IN_WIDTH-1:0] winner,
  output logic                any_valid
);

  logic [IN_WIDTH-1:0] cand;

  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = start + IN_WIDTH'(i);
      if (!any_valid && req[cand] && !excl[cand]) begin
        winner    = cand;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_grant_indexer.sv
// rr_grant_indexer: round-robin arbiter presenting the winner as a registered
// binary index plus valid strobe (select/enable of a downstream one-hot decoder).
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   req   [N_REQ]  request levels
//   owner_release  current owner ends its grant (ignored in IDLE); named this
//                  way because "release" is a reserved word in SystemVerilog
//   grant_idx      registered index of the current owner
//   grant_valid    registered, high while a grant is held
//   timeout        one-cycle pulse on a forced release
// Optional feature macro: RR_TIMEOUT_EN bounds each grant to MAX_HOLD+1 cycles;
// without it timeout is tied 0 and grants are unbounded.
module rr_grant_indexer
  import rr_pkg::*;
#(
  parameter int unsigned IN_WIDTH = DEF_IN_WIDTH,
  parameter int unsigned N_REQ    = DEF_N_REQ,
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic                owner_release,
  output logic [IN_WIDTH-1:0] grant_idx,
  output logic                grant_valid,
  output logic                timeout
);

  if (N_REQ != (1 << IN_WIDTH)) begin : g_bad_n_req
    $error("rr_grant_indexer: N_REQ must equal 2**IN_WIDTH");
  end
  if (MAX_HOLD == 0) begin : g_bad_max_hold
    $error("rr_grant_indexer: MAX_HOLD must be at least 1");
  end

  state_t              state, state_nx;
  logic [IN_WIDTH-1:0] last, last_nx, idx_nx, start, pick_idx;
  logic [N_REQ-1:0]    excl;
  logic                pick_any, owner_req, forced, end_cond, take, new_grant;

  assign start     = last + IN_WIDTH'(1);
  assign owner_req = req[grant_idx];
  // The departing owner is skipped; if nobody else wants the grant and the
  // owner still requests, it is regranted through the fallback in 'take'.
  assign excl      = (state == GRANT) ? (N_REQ'(1) << grant_idx) : '0;
  assign end_cond  = owner_release | ~owner_req | forced;
  assign take      = pick_any | owner_req;

  rr_pick #(
    .IN_WIDTH (IN_WIDTH),
    .N_REQ    (N_REQ)
  ) u_pick (
    .req       (req),
    .start     (start),
    .excl      (excl),
    .winner    (pick_idx),
    .any_valid (pick_any)
  );

`ifdef RR_TIMEOUT_EN
  localparam int unsigned CW = cnt_width(MAX_HOLD);
  logic [CW-1:0] hold_cnt;

  assign forced = (state == GRANT) && (hold_cnt == CW'(MAX_HOLD)) && !owner_release;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= forced;
      if (new_grant) hold_cnt <= '0;
      else if (state_nx == GRANT) hold_cnt <= hold_cnt + CW'(1);
    end
  end
`else
  assign forced  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (pick_any) state_nx = GRANT;
      GRANT:   if (end_cond && !take) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    idx_nx    = grant_idx;
    last_nx   = last;
    new_grant = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          idx_nx    = pick_idx;
          last_nx   = pick_idx;
          new_grant = 1'b1;
        end
      end
      GRANT: begin
        if (end_cond && take) begin
          idx_nx    = pick_any ? pick_idx : grant_idx;
          last_nx   = idx_nx;
          new_grant = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      last        <= IN_WIDTH'(N_REQ - 1);
    end else begin
      grant_idx   <= idx_nx;
      grant_valid <= (state_nx == GRANT);
      last        <= last_nx;
    end
  end

endmodule

// File: doc/rr_grant_indexer.md
Name: rr_grant_indexer

Overview:
- Round-robin arbiter that feeds the parameterized one-hot decoder stage directly downstream.
- Accepts N request lines and selects one requester fairly.
- Presents the winner as a registered binary index plus a valid strobe: grant_idx drives the decoder select, grant_valid drives its enable.
- Holds each grant until the owner releases it or drops its request.

Parameters:
- IN_WIDTH, 2, width of the binary grant index (matches decoder select width).
- N_REQ, 4, number of requesters; must equal 2**IN_WIDTH (elaboration-time assertion).
- MAX_HOLD, 15, hold-cycle limit; used only when RR_TIMEOUT_EN is defined.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N_REQ  per-requester request level.
- release  input  1  current owner finishes its grant; sampled only in GRANT.
- grant_idx  output  IN_WIDTH  registered binary index of the current owner.
- grant_valid  output  1  registered; high while a grant is held (decoder enable).
- timeout  output  1  one-cycle pulse on forced release; tied 0 without RR_TIMEOUT_EN.

Behaviour:
- Reset: asynchronous on rst_n low.
  - state=IDLE, grant_valid=0, grant_idx=0, timeout=0.
  - last pointer = N_REQ-1, so index 0 has top priority after reset.
- Reset asserted mid-grant drops grant_valid in the same cycle (asynchronously).
- FSM states: IDLE, GRANT.
- Priority rule: search starts at (last+1) mod N_REQ and wraps from N_REQ-1 to 0. The first set req bit wins.
- IDLE:
  - If req!=0 at a clock edge: register the winner into grant_idx, set grant_valid=1, set last=winner, go to GRANT.
  - Latency is one cycle: req seen at edge k gives grant_valid high after edge k.
  - If req==0: stay in IDLE, grant_valid=0, grant_idx holds its last value.
- GRANT:
  - An end condition is any of: release=1, req[grant_idx]=0, or a timeout.
  - On an end condition with other requests pending: regrant back-to-back to the next winner in the same edge. grant_valid stays 1 and grant_idx changes.
  - The departing owner is excluded from that search unless it is the only requester. In that case it is regranted.
  - On an end condition with no requests pending: go to IDLE, grant_valid=0.
  - Otherwise: hold grant_idx and grant_valid unchanged. New requests do not preempt the owner.
- release in IDLE is ignored.
- grant_idx never changes while grant_valid=1 except on a back-to-back handover edge.
- All outputs are registered; there is no combinational path from req to the outputs.

Optional Feature:
- RR_TIMEOUT_EN defined:
  - A hold counter of width clog2(MAX_HOLD+1) clears on each new grant and increments every GRANT cycle.
  - When the counter equals MAX_HOLD and no release occurs, a forced end condition applies and timeout pulses for one cycle.
  - The requester at grant_idx is excluded from the next search unless it is the only requester.
- RR_TIMEOUT_EN undefined: no counter exists, timeout is tied 0, and grants are unbounded.

Decomposition:
- Package rr_pkg:
  - state_t enum {IDLE, GRANT}.
  - Function clog2-based width helper.
  - Localparam default widths.
- Sub-module rr_pick: purely combinational rotating priority encoder.
  - Inputs: req, start pointer, exclude mask.
  - Outputs: winner index, any_valid.
  - The top module instantiates it once and holds the FSM, pointer and optional counter.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111, then release rst_n → cycle after first edge: grant_valid=1, grant_idx=0.
- Fairness: req=4'b1111 held, release pulsed every 3rd cycle → grant_idx sequence 0,1,2,3,0 with grant_valid continuously 1.
- Sparse/wrap: last=2, req=4'b0011 → next grant_idx=0 (wraps past 3); then release → grant_idx=1.
- Request drop: owner 1 deasserts req[1] with req=4'b0000 otherwise → next edge grant_valid=0, state IDLE; release in IDLE has no effect.
- Asynchronous reset mid-grant: rst_n low between edges while grant_idx=3 → grant_valid=0 immediately; after reset, req=4'b1000 → grant_idx=3 one cycle later.
- RR_TIMEOUT_EN with MAX_HOLD=4: req=4'b0101, no release → timeout pulse after 5 GRANT cycles, grant_idx moves 0→2; with only req[0] set → regranted to 0 with a timeout pulse.
